// File: rtl/dmem_responder.sv
// Data-memory target: word RAM plus memory-mapped LEDs, synchronised switches and an
// optional free-running timer (enabled by defining DMEM_TIMER_EN); sticky bus error on illegal writes.
module dmem_responder #(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 8,
  parameter int SW_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dmem_addr,
  input  logic             dmem_drw,
  input  logic [31:0]      dmem_data,
  output logic [31:0]      dmem_in,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] leds,
  output logic             bus_err
);

  localparam int          RAM_WORDS = 2 ** RAM_AW;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF010_0000;
  localparam logic [31:0] LED_ADDR  = 32'hF020_0000;
  localparam logic [31:0] TMR_ADDR  = 32'hF060_0000;

  logic [31:0]       ram_r [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx_s;
  logic              ram_hit_s;
  logic              sw_hit_s;
  logic              led_hit_s;
  logic              tmr_hit_s;
  logic              legal_wr_s;
  logic [31:0]       tmr_rd_s;
  logic [31:0]       rd_data_s;
  logic [SW_W-1:0]   s1_r;
  logic [SW_W-1:0]   s2_r;
  logic [LED_W-1:0]  leds_r;
  logic              bus_err_r;
  logic              unused_s;

  // Byte-offset bits are ignored: misaligned accesses hit the containing word.
  assign unused_s  = ^dmem_addr[1:0];
  assign ram_idx_s = dmem_addr[RAM_AW+1:2];
  assign ram_hit_s = (dmem_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
  assign sw_hit_s  = (dmem_addr[31:2] == SW_ADDR[31:2]);
  assign led_hit_s = (dmem_addr[31:2] == LED_ADDR[31:2]);

  // Switches are read-only, so only RAM, LEDs and (when present) the timer accept writes.
  assign legal_wr_s = ram_hit_s | led_hit_s | tmr_hit_s;

`ifdef DMEM_TIMER_EN
  logic [31:0] count_r;

  assign tmr_hit_s = (dmem_addr[31:2] == TMR_ADDR[31:2]);
  assign tmr_rd_s  = count_r;

  // Free-running counter; a software write replaces this cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (dmem_drw && tmr_hit_s) begin
      count_r <= dmem_data;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end
`else
  assign tmr_hit_s = 1'b0;
  assign tmr_rd_s  = 32'd0;
`endif

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && dmem_drw && ram_hit_s) begin
      ram_r[ram_idx_s] <= dmem_data;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
    end else begin
      s1_r <= sw;
      s2_r <= s1_r;
    end
  end

  // LED register and sticky bus-error flag; reset beats a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_r    <= '0;
      bus_err_r <= 1'b0;
    end else begin
      if (dmem_drw && led_hit_s) begin
        leds_r <= dmem_data[LED_W-1:0];
      end
      if (dmem_drw && !legal_wr_s) begin
        bus_err_r <= 1'b1;
      end
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero.
  always_comb begin
    rd_data_s = 32'd0;
    if (ram_hit_s) begin
      rd_data_s = ram_r[ram_idx_s];
    end else if (sw_hit_s) begin
      rd_data_s = 32'(s2_r);
    end else if (led_hit_s) begin
      rd_data_s = 32'(leds_r);
    end else if (tmr_hit_s) begin
      rd_data_s = tmr_rd_s;
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign dmem_in = rd_data_s;
  assign leds    = leds_r;
  assign bus_err = bus_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cycles push expectations, a negedge monitor checks them.
module tb_dmem_responder;

  localparam logic [31:0] SW_A  = 32'hF010_0000;
  localparam logic [31:0] LED_A = 32'hF020_0000;
  localparam logic [31:0] TMR_A = 32'hF060_0000;
`ifdef DMEM_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmem_addr = 32'd0;
  logic        dmem_drw = 1'b0;
  logic [31:0] dmem_data = 32'd0;
  logic [31:0] dmem_in;
  logic [7:0]  sw = 8'd0;
  logic [7:0]  leds;
  logic        bus_err;

  typedef struct {
    string       name;
    logic [2:0]  mask;   // [0] dmem_in, [1] leds, [2] bus_err
    logic [31:0] e_in;
    logic [7:0]  e_led;
    logic        e_err;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_addr (dmem_addr),
    .dmem_drw  (dmem_drw),
    .dmem_data (dmem_data),
    .dmem_in   (dmem_in),
    .sw        (sw),
    .leds      (leds),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.mask[0]) begin
        n_total++;
        if (dmem_in !== e.e_in) $display("FAIL %s dmem_in got=%h want=%h", e.name, dmem_in, e.e_in);
        else n_pass++;
      end
      if (e.mask[1]) begin
        n_total++;
        if (leds !== e.e_led) $display("FAIL %s leds got=%h want=%h", e.name, leds, e.e_led);
        else n_pass++;
      end
      if (e.mask[2]) begin
        n_total++;
        if (bus_err !== e.e_err) $display("FAIL %s bus_err got=%b want=%b", e.name, bus_err, e.e_err);
        else n_pass++;
      end
    end
  end

  task automatic step(input string name, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [2:0] mask, input logic [31:0] ein, input logic [7:0] eled,
                      input logic eerr);
    exp_t e;
    rst       = 1'b0;
    dmem_addr = a;
    dmem_drw  = w;
    dmem_data = d;
    if (mask != 3'd0) begin
      e.name = name; e.mask = mask; e.e_in = ein; e.e_led = eled; e.e_err = eerr;
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Reset with an LED write held during it; the write must be discarded.
  task automatic do_reset();
    rst       = 1'b1;
    dmem_addr = LED_A;
    dmem_drw  = 1'b1;
    dmem_data = 32'h0000_00FF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    step("rst_state", LED_A, 1'b0, 32'd0, 3'b111, 32'd0, 8'h00, 1'b0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin : stim
    #1;
    do_reset();
    step("tmr1", TMR_A, 1'b0, 32'd0, 3'b101, TEN ? 32'd1 : 32'd0, 8'h00, 1'b0);
    step("tmr2", TMR_A, 1'b0, 32'd0, 3'b001, TEN ? 32'd2 : 32'd0, 8'h00, 1'b0);
    step("tmr3", TMR_A, 1'b0, 32'd0, 3'b001, TEN ? 32'd3 : 32'd0, 8'h00, 1'b0);

    step("ram_pre",   32'h1000_0010, 1'b1, 32'h1111_1111, 3'b110, 32'd0, 8'h00, 1'b0);
    step("ram_old",   32'h1000_0010, 1'b1, 32'hDEAD_BEEF, 3'b001, 32'h1111_1111, 8'h00, 1'b0);
    step("ram_new",   32'h1000_0010, 1'b0, 32'd0, 3'b001, 32'hDEAD_BEEF, 8'h00, 1'b0);
    step("ram_mis",   32'h1000_0013, 1'b0, 32'd0, 3'b101, 32'hDEAD_BEEF, 8'h00, 1'b0);
    step("ram_top_w", 32'h1000_0FFC, 1'b1, 32'h1234_5678, 3'b100, 32'd0, 8'h00, 1'b0);
    step("ram_top_r", 32'h1000_0FFC, 1'b0, 32'd0, 3'b001, 32'h1234_5678, 8'h00, 1'b0);
    step("ram_w0",    32'h1000_0000, 1'b1, 32'hCAFE_F00D, 3'b000, 32'd0, 8'h00, 1'b0);
    step("ram_r0",    32'h1000_0000, 1'b0, 32'd0, 3'b001, 32'hCAFE_F00D, 8'h00, 1'b0);

    step("led_w", LED_A, 1'b1, 32'hFFFF_FFA5, 3'b011, 32'd0, 8'h00, 1'b0);
    step("led_r", LED_A, 1'b0, 32'd0, 3'b111, 32'h0000_00A5, 8'hA5, 1'b0);

    sw = 8'h3C;
    step("sw_old0", SW_A, 1'b0, 32'd0, 3'b001, 32'd0, 8'h00, 1'b0);
    step("sw_old1", SW_A, 1'b0, 32'd0, 3'b001, 32'd0, 8'h00, 1'b0);
    step("sw_new",  SW_A, 1'b0, 32'd0, 3'b101, 32'h0000_003C, 8'h00, 1'b0);

    step("unm_r",  32'h2000_0000, 1'b0, 32'd0, 3'b101, 32'd0, 8'h00, 1'b0);
    step("past_r", 32'h1000_1000, 1'b0, 32'd0, 3'b101, 32'd0, 8'h00, 1'b0);
`ifdef DMEM_TIMER_EN
    step("tmr_w",    TMR_A, 1'b1, 32'hFFFF_FFFE, 3'b100, 32'd0, 8'h00, 1'b0);
    step("tmr_fe",   TMR_A, 1'b0, 32'd0, 3'b101, 32'hFFFF_FFFE, 8'h00, 1'b0);
    step("tmr_ff",   TMR_A, 1'b0, 32'd0, 3'b001, 32'hFFFF_FFFF, 8'h00, 1'b0);
    step("tmr_wrap", TMR_A, 1'b0, 32'd0, 3'b001, 32'h0000_0000, 8'h00, 1'b0);
`else
    step("tmr_off_r", TMR_A, 1'b0, 32'd0, 3'b101, 32'd0, 8'h00, 1'b0);
`endif

    // Unmapped write: error set, nothing else disturbed.
    step("unm_w",   32'h2000_0000, 1'b1, 32'hFFFF_FFFF, 3'b100, 32'd0, 8'h00, 1'b0);
    step("unm_err", LED_A, 1'b0, 32'd0, 3'b111, 32'h0000_00A5, 8'hA5, 1'b1);
    step("unm_ram", 32'h1000_0010, 1'b0, 32'd0, 3'b101, 32'hDEAD_BEEF, 8'h00, 1'b1);
    do_reset();

    // Switch write is illegal; error stays set across a later legal write.
    step("sw_w",       SW_A, 1'b1, 32'd0, 3'b100, 32'd0, 8'h00, 1'b0);
    step("sw_err",     SW_A, 1'b0, 32'd0, 3'b101, 32'h0000_003C, 8'h00, 1'b1);
    step("legal_w",    LED_A, 1'b1, 32'h0000_005A, 3'b100, 32'd0, 8'h00, 1'b1);
    step("err_sticky", LED_A, 1'b0, 32'd0, 3'b111, 32'h0000_005A, 8'h5A, 1'b1);
    do_reset();

    // First word past RAM must not alias onto word 0.
    step("past_w",   32'h1000_1000, 1'b1, 32'hBAD0_BAD0, 3'b100, 32'd0, 8'h00, 1'b0);
    step("past_err", 32'h1000_0000, 1'b0, 32'd0, 3'b101, 32'hCAFE_F00D, 8'h00, 1'b1);
    do_reset();

`ifndef DMEM_TIMER_EN
    step("tmr_off_w",   TMR_A, 1'b1, 32'h0000_0001, 3'b100, 32'd0, 8'h00, 1'b0);
    step("tmr_off_err", TMR_A, 1'b0, 32'd0, 3'b101, 32'd0, 8'h00, 1'b1);
    do_reset();
`endif

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
